// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// When OVERFLOW_FLAG_EN is defined, the bundle also carries the signed-overflow flag V.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bo;
`ifdef OVERFLOW_FLAG_EN
  logic             V;
`endif

  modport master (
    output start, A, B,
    input  busy, done, D, Bo
`ifdef OVERFLOW_FLAG_EN
    , input V
`endif
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, Bo
`ifdef OVERFLOW_FLAG_EN
    , output V
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop make up the datapath.
// A start/busy/done handshake runs one operation every WIDTH+1 cycles.
// Optional feature macro: OVERFLOW_FLAG_EN adds the registered signed-overflow output V.
//
// state | meaning
// IDLE  | waiting for start; D/Bo hold the last result
// SHIFT | one difference bit per edge; busy=1
// DONE  | done=1 for one cycle; start here begins the next operation immediately
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic [CNT_W-1:0] count;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
`ifdef OVERFLOW_FLAG_EN
  logic             v_q;
`endif

  // Full-subtractor cell working on the current LSBs and the stored borrow.
  logic ai;
  logic bi;
  logic di;
  logic br_next;

  assign ai      = a_sh[0];
  assign bi      = b_sh[0];
  assign di      = ai ^ bi ^ br;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br);

  // Sequencer and datapath; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      br     <= 1'b0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      d_q    <= '0;
      bo_q   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      v_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            br     <= 1'b0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= {di, r_sh[WIDTH-1:1]};
          br    <= br_next;
          count <= count + CNT_W'(1);
          if (count == LAST_BIT) begin
            // On the last bit ai/bi are the operand sign bits and di is the result sign.
            d_q    <= {di, r_sh[WIDTH-1:1]};
            bo_q   <= br_next;
`ifdef OVERFLOW_FLAG_EN
            v_q    <= (ai != bi) && (di != ai);
`endif
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            br     <= 1'b0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bo   = bo_q;
`ifdef OVERFLOW_FLAG_EN
  assign bus.V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): directed corner cases plus random operands
// compared against an arithmetic reference. Covers V when OVERFLOW_FLAG_EN is defined.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain modular and signed arithmetic.
  function automatic logic [W-1:0] ref_d(input int a, input int b);
    int diff;
    diff = (a - b) & ((1 << W) - 1);
    return diff[W-1:0];
  endfunction

  function automatic logic ref_bo(input int a, input int b);
    return (a < b);
  endfunction

  function automatic logic ref_v(input int a, input int b);
    int sa, sb, full;
    sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    full = sa - sb;
    return (full > (1 << (W - 1)) - 1) || (full < -(1 << (W - 1)));
  endfunction

  // Advance edge by edge (sampling 1ns after each) until done or the budget expires.
  task automatic wait_done(input int budget, output bit seen, output int edges);
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  // Present operands with start for one accepting edge; returns 1ns after that edge.
  task automatic issue(input int a, input int b);
    @(negedge clk);
    bus.A     = W'(a);
    bus.B     = W'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== '0 || bus.Bo !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b D=%0d Bo=%b, required all 0",
               bus.busy, bus.done, bus.D, bus.Bo);
    end
`ifdef OVERFLOW_FLAG_EN
    checks++;
    if (bus.V !== 1'b0) begin
      errors++;
      $display("FAIL reset_v: V=%b, required 0", bus.V);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // 5 - 3: busy for W cycles, done pulse W edges after the accepting edge, D held until then.
  task automatic test_basic();
    logic [W-1:0] d_before;
    int busy_cnt;
    int done_at;
    d_before = bus.D;
    busy_cnt = 0;
    done_at  = -1;
    issue(5, 3);
    if (bus.busy === 1'b1) busy_cnt++;
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1 && done_at < 0) done_at = i;
      if (i < W) begin
        checks++;
        if (bus.D !== d_before) begin
          errors++;
          $display("FAIL basic_hold: D=%0d during busy, required %0d", bus.D, d_before);
        end
      end
      if (i == W) begin
        checks++;
        if (bus.D !== 4'd2 || bus.Bo !== 1'b0) begin
          errors++;
          $display("FAIL basic_result: D=%0d Bo=%b, required D=2 Bo=0", bus.D, bus.Bo);
        end
      end
    end
    checks++;
    if (busy_cnt != W) begin
      errors++;
      $display("FAIL basic_busy_len: busy cycles=%0d, required %0d", busy_cnt, W);
    end
    checks++;
    if (done_at != W) begin
      errors++;
      $display("FAIL basic_latency: done at edge %0d after start, required %0d", done_at, W);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", bus.done);
    end
  endtask

  // Directed corners followed by random operands.
  task automatic test_arith();
    int av[$];
    int bv[$];
    bit seen;
    int edges;
    av = '{3, 0, 15, 0, 15, 8, 7};
    bv = '{5, 1, 15, 0, 0, 1, 15};
    for (int i = 0; i < 30; i++) begin
      av.push_back(int'($urandom_range(0, (1 << W) - 1)));
      bv.push_back(int'($urandom_range(0, (1 << W) - 1)));
    end
    foreach (av[i]) begin
      issue(av[i], bv[i]);
      wait_done(W + 4, seen, edges);
      checks++;
      if (!seen || edges != W) begin
        errors++;
        $display("FAIL arith_latency: A=%0d B=%0d seen=%0b edges=%0d, required edges=%0d",
                 av[i], bv[i], seen, edges, W);
      end
      checks++;
      if (bus.D !== ref_d(av[i], bv[i]) || bus.Bo !== ref_bo(av[i], bv[i])) begin
        errors++;
        $display("FAIL arith_result: A=%0d B=%0d D=%0d Bo=%b, required D=%0d Bo=%b",
                 av[i], bv[i], bus.D, bus.Bo, ref_d(av[i], bv[i]), ref_bo(av[i], bv[i]));
      end
`ifdef OVERFLOW_FLAG_EN
      checks++;
      if (bus.V !== ref_v(av[i], bv[i])) begin
        errors++;
        $display("FAIL arith_v: A=%0d B=%0d V=%b, required %b",
                 av[i], bv[i], bus.V, ref_v(av[i], bv[i]));
      end
`endif
    end
  endtask

  // Start pulses and operand changes while busy must not disturb the running subtraction.
  task automatic test_start_during_busy();
    bit seen;
    int edges;
    int extra;
    issue(9, 4);
    for (int i = 0; i < W - 1; i++) begin
      @(negedge clk);
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(W + 4, seen, edges);
    checks++;
    if (!seen || bus.D !== 4'd5 || bus.Bo !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: seen=%0b D=%0d Bo=%b, required D=5 Bo=0", seen, bus.D, bus.Bo);
    end
    extra = 0;
    repeat (3 * W) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_single_done: extra done pulses=%0d, required 0", extra);
    end
  endtask

  // start held high: done every W+1 edges, each with the operands present at its capture.
  task automatic test_back_to_back();
    int av[4];
    int bv[4];
    bit seen;
    int edges;
    foreach (av[i]) begin
      av[i] = int'($urandom_range(0, (1 << W) - 1));
      bv[i] = int'($urandom_range(0, (1 << W) - 1));
    end
    @(negedge clk);
    bus.A     = W'(av[0]);
    bus.B     = W'(bv[0]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_done(2 * W + 4, seen, edges);
      checks++;
      if (!seen || edges != ((i == 0) ? W : W + 1)) begin
        errors++;
        $display("FAIL b2b_spacing: op %0d seen=%0b edges=%0d, required %0d",
                 i, seen, edges, (i == 0) ? W : W + 1);
      end
      checks++;
      if (bus.D !== ref_d(av[i], bv[i]) || bus.Bo !== ref_bo(av[i], bv[i])) begin
        errors++;
        $display("FAIL b2b_result: op %0d D=%0d Bo=%b, required D=%0d Bo=%b",
                 i, bus.D, bus.Bo, ref_d(av[i], bv[i]), ref_bo(av[i], bv[i]));
      end
      if (i < 3) begin
        bus.A = W'(av[i + 1]);
        bus.B = W'(bv[i + 1]);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset during the second SHIFT cycle clears outputs at once; no done follows.
  task automatic test_reset_mid_op();
    int dones;
    issue(12, 3);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== '0 || bus.Bo !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b done=%b D=%0d Bo=%b, required all 0",
               bus.busy, bus.done, bus.D, bus.Bo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (3 * W) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midop_no_done: busy/done cycles after reset=%0d, required 0", dones);
    end
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_overflow();
    int av[3];
    int bv[3];
    logic [W-1:0] dv[3];
    logic bov[3];
    logic vv[3];
    bit seen;
    int edges;
    av  = '{8, 7, 5};
    bv  = '{1, 15, 3};
    dv  = '{4'd7, 4'd8, 4'd2};
    bov = '{1'b0, 1'b1, 1'b0};
    vv  = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i]);
      wait_done(W + 4, seen, edges);
      checks++;
      if (!seen || bus.D !== dv[i] || bus.Bo !== bov[i] || bus.V !== vv[i]) begin
        errors++;
        $display("FAIL overflow: A=%0d B=%0d seen=%0b D=%0d Bo=%b V=%b, required D=%0d Bo=%b V=%b",
                 av[i], bv[i], seen, bus.D, bus.Bo, bus.V, dv[i], bov[i], vv[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_op();
`ifdef OVERFLOW_FLAG_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
